flexsipo_ifft: RTL and testbench
================================

# flexsipo_ifft

Flexible serial-in/parallel-out collector that gathers complex samples streamed out of the IFFT-side PISO into one parallel frame of up to FRAME_LENGTH entries. It sits directly downstream of the PISO: its inputs mirror the PISO's serial sample, valid and done outputs. It presents the frame to the next stage with a valid/ready handshake. Unwritten entries are zero-filled.

## Interface
- DATA_WIDTH, 16, signed sample width per real/imag component
- FRAME_LENGTH, 12, maximum frame entries
- IS_COMP, 1, 1 = complex (index 0 real, 1 imag), 0 = real only
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset; synchronous, active-high
- i_sin  in  signed [DATA_WIDTH-1:0] [0:IS_COMP]  serial sample
- i_valid  in  1  i_sin valid this cycle
- i_last  in  1  last sample of frame; qualified by i_valid
- i_limit  in  [$clog2(FRAME_LENGTH):0]  expected frame length; 0 or >FRAME_LENGTH treated as FRAME_LENGTH; sampled at first sample of frame
- o_pout  out  signed [DATA_WIDTH-1:0] [0:FRAME_LENGTH-1][0:IS_COMP]  collected frame, registered
- o_valid  out  1  frame available
- i_ready  in  1  consumer accepts frame
- o_count  out  [$clog2(FRAME_LENGTH):0]  samples written in held frame
- o_short  out  1  held frame closed by i_last before limit
- o_overflow  out  1  sticky: a sample was dropped

## Operation
- FSM states IDLE, FILL, HOLD.
- IDLE: o_valid=0. On i_valid: latch limit L, clear buffer to zero, write sample to index 0, count=1 → FILL; if i_last or L==1 → HOLD directly.
- FILL: each i_valid writes entry at index count, count+1. Frame closes when i_last, or count+1==L → HOLD. Cycles without i_valid hold state (gaps allowed).
- HOLD: o_valid=1, o_pout/o_count/o_short stable. i_ready → frame consumed.
  - i_ready & i_valid same cycle: frame consumed, the new sample starts the next frame (index 0, new L latched, buffer cleared except index 0) → FILL, or HOLD if it is also last/L==1.
  - i_ready only → IDLE.
  - i_valid without i_ready: sample dropped, o_overflow set (cleared only by i_rst).
- o_short = 1 iff closed by i_last with count < L.
- i_last asserted when count+1==L: normal close, o_short=0.
- Samples stored verbatim; no arithmetic, no saturation.

## Timing
- Reset (i_rst at rising edge): state IDLE, o_pout all zero, o_valid=0, o_count=0, o_short=0, o_overflow=0; reset mid-FILL or mid-HOLD discards the frame.
- Latency: closing sample at edge n → o_valid=1 after edge n; o_pout complete in the same cycle.
- Throughput: one sample per cycle; back-to-back frames with no bubble when i_ready is high in the first HOLD cycle.
- o_valid never deasserts without i_ready (or reset).

## Configuration
- FLEXSIPO_REVERSE_EN defined: arrival k written to index L-1-k, so a PISO-serialized vector is restored to its original order. Zero fill remains at indices ≥ L.
- FLEXSIPO_REVERSE_EN undefined: arrival k written to index k.
- All other behaviour is identical in both builds.

## Structure
- Shared package ifft_pkg holds:
  - typedef sample_t (signed [DATA_WIDTH-1:0] [0:IS_COMP])
  - enum sipo_state_t {IDLE, FILL, HOLD}
  - function clamp_limit(): the 0/oversize → FRAME_LENGTH rule
- One sub-module, frame_ctr: write-index counter with load, increment and terminal-count compare. Returns the write index (forward or reversed) and the close flag.

## Test plan
- FRAME_LENGTH=12, i_limit=12, samples (k, -k) for k=0..11 back-to-back, i_ready=1 → o_valid one cycle after k=11. Forward build: o_pout[k]=(k,-k). Reverse build: o_pout[11-k]=(k,-k). o_count=12, o_short=0.
- i_limit=12, 5 samples with i_last on the 5th → HOLD, o_count=5, o_short=1, entries 5..11 = 0.
- i_limit=0 → treated as 12; i_limit=1 with a single sample → HOLD after one edge, o_count=1.
- HOLD with i_ready=0 for 3 cycles while i_valid=1 → o_pout unchanged, o_overflow=1 and stays 1 after the frame is consumed.
- Two frames back-to-back, i_ready=1 in the same cycle the next frame's first sample arrives → no sample lost, second frame index 0 correct, o_overflow=0.
- Assert i_rst mid-FILL after 6 samples → next cycle all outputs zero, state IDLE; the subsequent full frame collects correctly.

Source files
------------

// File: rtl/ifft_pkg.sv
// ifft_pkg: shared sample type, SIPO state encoding and frame-limit clamp rule
package ifft_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FRAME_LENGTH = 12;
  localparam int DEF_IS_COMP = 1;
  typedef logic signed [0:DEF_IS_COMP][DEF_DATA_WIDTH-1:0] sample_t;
  typedef enum logic [1:0] {IDLE, FILL, HOLD} sipo_state_t;
  function automatic int clamp_limit(input int lim, input int frame_len);
    return (lim == 0 || lim > frame_len) ? frame_len : lim;
  endfunction
endpackage

// File: rtl/flexsipo_ifft_frame_ctr.sv
// frame_ctr: write-index counter with limit latch and close detect; FLEXSIPO_REVERSE_EN reverses the index
module frame_ctr #(
  parameter int FRAME_LENGTH = 12,
  parameter int CW = $clog2(FRAME_LENGTH) + 1,
  parameter int IW = $clog2(FRAME_LENGTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          inc_i,
  input  logic          clr_i,
  input  logic [CW-1:0] lim_i,
  output logic [CW-1:0] count_o,
  output logic [IW-1:0] idx_o,
  output logic          close_o
);
  logic [CW-1:0] count_q, lim_q, k, l;
  assign k = load_i ? '0 : count_q;
  assign l = load_i ? lim_i : lim_q;
  assign close_o = (k + CW'(1)) == l;
  assign count_o = count_q;
`ifdef FLEXSIPO_REVERSE_EN
  assign idx_o = IW'(l - k - CW'(1));
`else
  assign idx_o = IW'(k);
`endif
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      count_q <= '0;
      lim_q <= '0;
    end else if (load_i) begin
      count_q <= CW'(1);
      lim_q <= lim_i;
    end else if (inc_i) begin
      count_q <= count_q + CW'(1);
    end
  end
endmodule

// File: rtl/flexsipo_ifft.sv
// flexsipo_ifft: serial-to-parallel frame collector with valid/ready output; FLEXSIPO_REVERSE_EN restores PISO order
module flexsipo_ifft
  import ifft_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FRAME_LENGTH = DEF_FRAME_LENGTH,
  parameter int IS_COMP = DEF_IS_COMP
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic signed [0:IS_COMP][DATA_WIDTH-1:0] i_sin,
  input  logic i_valid,
  input  logic i_last,
  input  logic [$clog2(FRAME_LENGTH):0] i_limit,
  output logic signed [0:FRAME_LENGTH-1][0:IS_COMP][DATA_WIDTH-1:0] o_pout,
  output logic o_valid,
  input  logic i_ready,
  output logic [$clog2(FRAME_LENGTH):0] o_count,
  output logic o_short,
  output logic o_overflow
);
  localparam int CW = $clog2(FRAME_LENGTH) + 1;
  localparam int IW = $clog2(FRAME_LENGTH);
  sipo_state_t state_q;
  logic signed [0:FRAME_LENGTH-1][0:IS_COMP][DATA_WIDTH-1:0] frame_q, frame_d;
  logic valid_q, short_q, ovf_q, start, inc, clr, wr, cc, close;
  logic [CW-1:0] lim_in;
  logic [IW-1:0] idx;
  assign lim_in = CW'(clamp_limit(int'(i_limit), FRAME_LENGTH));
  // a new frame starts from IDLE, or from HOLD when the held frame is consumed in the same cycle
  assign start = i_valid && (state_q == IDLE || (state_q == HOLD && i_ready));
  assign inc = i_valid && state_q == FILL;
  assign clr = state_q == HOLD && i_ready && !i_valid;
  assign wr = start || inc;
  assign close = cc || i_last;
  frame_ctr #(.FRAME_LENGTH(FRAME_LENGTH), .CW(CW), .IW(IW)) u_ctr (
    .clk(i_clk),
    .rst(i_rst),
    .load_i(start),
    .inc_i(inc),
    .clr_i(clr),
    .lim_i(lim_in),
    .count_o(o_count),
    .idx_o(idx),
    .close_o(cc)
  );
  always_comb begin
    frame_d = start ? '0 : frame_q;
    if (wr) frame_d[idx] = i_sin;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      frame_q <= '0;
      valid_q <= 1'b0;
      short_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      frame_q <= frame_d;
      ovf_q <= ovf_q | (state_q == HOLD && i_valid && !i_ready);
      if (wr && close) begin
        state_q <= HOLD;
        valid_q <= 1'b1;
        short_q <= i_last && !cc;
      end else if (wr || clr) begin
        state_q <= wr ? FILL : IDLE;
        valid_q <= 1'b0;
        short_q <= 1'b0;
      end
    end
  end
  assign o_pout = frame_q;
  assign o_valid = valid_q;
  assign o_short = short_q;
  assign o_overflow = ovf_q;
endmodule

// File: tb/tb_flexsipo_ifft.sv
// tb_flexsipo_ifft: directed and randomized frame checks against a list-based frame model
module tb_flexsipo_ifft;
  localparam int FL = 12;
  localparam int PW = FL * 2 * 16;
  logic clk = 1'b0;
  logic rst, i_valid, i_last, i_ready, o_valid, o_short, o_overflow;
  logic signed [0:1][15:0] i_sin;
  logic [4:0] i_limit, o_count;
  logic signed [0:FL-1][0:1][15:0] o_pout;
  logic [0:1][15:0] samp [FL];
  logic [0:FL-1][0:1][15:0] exp_pout;
  int n_cmp = 0;
  int n_bad = 0;
  bit holding;

  always #5 clk = ~clk;

  flexsipo_ifft dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_sin(i_sin),
    .i_valid(i_valid),
    .i_last(i_last),
    .i_limit(i_limit),
    .o_pout(o_pout),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_count(o_count),
    .o_short(o_short),
    .o_overflow(o_overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic int clamp_l(input int lim);
    return (lim == 0 || lim > FL) ? FL : lim;
  endfunction

  task automatic fill_rand();
    for (int k = 0; k < FL; k++) samp[k] = {16'($urandom), 16'($urandom)};
  endtask

  // expected frame: arrival k lands at k (or L-1-k reversed), all else zero
  task automatic check_frame(input string tag, input int lim, input int n);
    int l;
    l = clamp_l(lim);
    exp_pout = '0;
    for (int k = 0; k < n; k++) begin
`ifdef FLEXSIPO_REVERSE_EN
      exp_pout[l-1-k] = samp[k];
`else
      exp_pout[k] = samp[k];
`endif
    end
    chk({tag, ".valid"}, PW'(o_valid), PW'(1));
    chk({tag, ".count"}, PW'(o_count), PW'(n));
    chk({tag, ".short"}, PW'(o_short), PW'(n < l));
    chk({tag, ".pout"}, PW'(o_pout), PW'(exp_pout));
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".valid"}, PW'(o_valid), PW'(0));
    chk({tag, ".count"}, PW'(o_count), PW'(0));
    chk({tag, ".short"}, PW'(o_short), PW'(0));
    chk({tag, ".ovf"}, PW'(o_overflow), PW'(0));
    chk({tag, ".pout"}, PW'(o_pout), PW'(0));
  endtask

  task automatic run_frame(input int lim, input int n, input bit last, input bit rdy_first,
                           input bit gaps, input string tag);
    i_limit = 5'(lim);
    for (int k = 0; k < n; k++) begin
      if (gaps && k > 0 && $urandom_range(0, 3) == 0) begin
        i_valid = 1'b0;
        i_last = 1'b0;
        i_ready = 1'b0;
        tick();
      end
      i_valid = 1'b1;
      i_sin = samp[k];
      i_last = last && (k == n - 1);
      i_ready = rdy_first && (k == 0);
      tick();
      i_limit = 5'($urandom_range(0, 31));
      if (k < n - 1) chk({tag, ".early"}, PW'(o_valid), PW'(0));
    end
    i_valid = 1'b0;
    i_last = 1'b0;
    i_ready = 1'b0;
    check_frame(tag, lim, n);
  endtask

  task automatic consume(input string tag);
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk({tag, ".idle"}, PW'(o_valid), PW'(0));
  endtask

  initial begin
    int lim, n;
    bit last, rdy;
    rst = 1'b1;
    i_valid = 1'b0;
    i_last = 1'b0;
    i_ready = 1'b0;
    i_sin = '0;
    i_limit = '0;
    tick();
    tick();
    rst = 1'b0;
    check_reset("reset");

    for (int k = 0; k < FL; k++) samp[k] = {16'(k), 16'(-k)};
    run_frame(12, 12, 1'b0, 1'b0, 1'b0, "full12");
    consume("full12");

    fill_rand();
    run_frame(12, 5, 1'b1, 1'b0, 1'b1, "short5");
    consume("short5");

    fill_rand();
    run_frame(0, 12, 1'b0, 1'b0, 1'b1, "lim0");
    consume("lim0");

    fill_rand();
    run_frame(1, 1, 1'b0, 1'b0, 1'b0, "lim1");
    consume("lim1");

    fill_rand();
    run_frame(15, 12, 1'b0, 1'b0, 1'b1, "lim15");
    consume("lim15");

    fill_rand();
    run_frame(4, 4, 1'b1, 1'b0, 1'b0, "last_at_l");
    i_valid = 1'b1;
    i_ready = 1'b0;
    repeat (3) begin
      i_sin = {16'($urandom), 16'($urandom)};
      tick();
    end
    i_valid = 1'b0;
    check_frame("ovf_hold", 4, 4);
    chk("ovf_set", PW'(o_overflow), PW'(1));
    consume("ovf");
    chk("ovf_sticky", PW'(o_overflow), PW'(1));

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("reset2");

    fill_rand();
    run_frame(3, 3, 1'b0, 1'b0, 1'b0, "b2b_a");
    fill_rand();
    run_frame(12, 12, 1'b0, 1'b1, 1'b0, "b2b_b");
    chk("b2b_ovf", PW'(o_overflow), PW'(0));
    consume("b2b_b");

    holding = 1'b0;
    for (int it = 0; it < 30; it++) begin
      lim = $urandom_range(0, 15);
      last = 1'($urandom_range(0, 1));
      n = last ? $urandom_range(1, clamp_l(lim)) : clamp_l(lim);
      rdy = holding && ($urandom_range(0, 1) == 1);
      if (holding && !rdy) consume("rnd");
      fill_rand();
      run_frame(lim, n, last, rdy, 1'b1, "rnd");
      holding = 1'b1;
    end
    consume("rnd_end");
    chk("rnd_ovf", PW'(o_overflow), PW'(0));

    fill_rand();
    i_limit = 5'd12;
    for (int k = 0; k < 6; k++) begin
      i_valid = 1'b1;
      i_sin = samp[k];
      tick();
    end
    i_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("rst_fill");
    fill_rand();
    run_frame(12, 12, 1'b0, 1'b0, 1'b0, "after_rst");
    consume("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
